// File: rtl/branch_sequencer.sv
// Decode-stage next-PC sequencer: picks sequential/branch/jump/register target,
// stalls for operand forwarding and parks a redirect until Fetch accepts it.
// Optional branch-likely delay-slot nullification under `BRANCH_LIKELY_EN.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        JrD,
  input  logic        LikelyD,
  input  logic        JudgeRes,
  input  logic        OperandReady,
  input  logic        FetchReady,
  input  logic [31:0] PC4F,
  input  logic [31:0] B_addr,
  input  logic [31:0] J_addr,
  input  logic [31:0] JR_addr,
  output logic [31:0] NPC,
  output logic        PC_En,
  output logic        StallD,
  output logic        Redirect,
  output logic        FlushD
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] tgt_q, tgt_nxt;
  logic [31:0] target;
  logic        needop, taken;
  logic        flush_pend;
  logic [31:0] npc_c;
  logic        pc_en_c, stall_c, redirect_c, flush_c;

  assign needop = BranchD | JrD;
  assign taken  = JrD | JumpD | (BranchD & JudgeRes);
  assign target = JrD ? JR_addr : (JumpD ? J_addr : B_addr);

`ifdef BRANCH_LIKELY_EN
  logic flush_q, flush_nxt;
  logic likely_nt;

  // Not-taken likely branch: sequential path, but the delay slot is squashed.
  assign likely_nt  = BranchD & LikelyD & OperandReady & ~JudgeRes;
  assign flush_pend = flush_q;

  always_ff @(posedge clk) begin
    if (reset) flush_q <= 1'b0;
    else       flush_q <= flush_nxt;
  end
`else
  logic unused_likely;
  assign unused_likely = LikelyD;
  assign flush_pend    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      tgt_q <= 32'h0;
    end else begin
      state <= state_nxt;
      tgt_q <= tgt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tgt_nxt    = tgt_q;
    npc_c      = PC4F;
    pc_en_c    = 1'b0;
    stall_c    = 1'b0;
    redirect_c = 1'b0;
    flush_c    = 1'b0;
`ifdef BRANCH_LIKELY_EN
    flush_nxt  = flush_q;
`endif
    case (state)
      PEND: begin
        stall_c = 1'b1;
        npc_c   = tgt_q;
        if (FetchReady) begin
          pc_en_c    = 1'b1;
          redirect_c = ~flush_pend;
          flush_c    = flush_pend;
          state_nxt  = RUN;
        end
      end
      default: begin
        // HOLD with operands ready resolves exactly like RUN in the same cycle.
        if (!OperandReady && (state == HOLD || needop)) begin
          stall_c   = 1'b1;
          state_nxt = HOLD;
        end else if (taken) begin
          if (FetchReady) begin
            npc_c      = target;
            pc_en_c    = 1'b1;
            redirect_c = 1'b1;
            state_nxt  = RUN;
          end else begin
            tgt_nxt   = target;
            stall_c   = 1'b1;
            state_nxt = PEND;
`ifdef BRANCH_LIKELY_EN
            flush_nxt = 1'b0;
`endif
          end
`ifdef BRANCH_LIKELY_EN
        end else if (likely_nt) begin
          if (FetchReady) begin
            flush_c   = 1'b1;
            pc_en_c   = 1'b1;
            state_nxt = RUN;
          end else begin
            tgt_nxt   = PC4F;
            flush_nxt = 1'b1;
            stall_c   = 1'b1;
            state_nxt = PEND;
          end
`endif
        end else begin
          pc_en_c   = FetchReady;
          stall_c   = ~FetchReady;
          state_nxt = RUN;
        end
      end
    endcase
  end

  // Reset forces the quiescent output pattern regardless of state.
  always_comb begin
    if (reset) begin
      NPC      = RESET_PC;
      PC_En    = 1'b0;
      StallD   = 1'b0;
      Redirect = 1'b0;
      FlushD   = 1'b0;
    end else begin
      NPC      = npc_c;
      PC_En    = pc_en_c;
      StallD   = stall_c;
      Redirect = redirect_c;
      FlushD   = flush_c;
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_branch_sequencer;

`ifdef BRANCH_LIKELY_EN
  localparam bit LIKELY_EN = 1'b1;
`else
  localparam bit LIKELY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        BranchD, JumpD, JrD, LikelyD, JudgeRes, OperandReady, FetchReady;
  logic [31:0] PC4F, B_addr, J_addr, JR_addr;
  logic [31:0] NPC;
  logic        PC_En, StallD, Redirect, FlushD;

  int checks = 0;
  int failures = 0;

  branch_sequencer dut (
    .clk(clk), .reset(reset),
    .BranchD(BranchD), .JumpD(JumpD), .JrD(JrD), .LikelyD(LikelyD),
    .JudgeRes(JudgeRes), .OperandReady(OperandReady), .FetchReady(FetchReady),
    .PC4F(PC4F), .B_addr(B_addr), .J_addr(J_addr), .JR_addr(JR_addr),
    .NPC(NPC), .PC_En(PC_En), .StallD(StallD), .Redirect(Redirect), .FlushD(FlushD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a parked redirect (address + whether it is a squashing sequential exit)
  // and whether the current control instruction is still waiting for operands.
  bit          pend_v, pend_flush, waiting;
  logic [31:0] pend_addr;

  always @(negedge clk) begin
    logic [31:0] e_npc, dest;
    bit e_npc_v, e_pcen, e_stall, e_redir, e_flush, is_taken;
    e_npc = PC4F; e_npc_v = 1'b0; e_pcen = 1'b0; e_stall = 1'b0;
    e_redir = 1'b0; e_flush = 1'b0;
    if (reset) begin
      e_npc = 32'h0000_3000; e_npc_v = 1'b1;
      pend_v = 1'b0; pend_flush = 1'b0; waiting = 1'b0;
    end else if (pend_v) begin
      e_stall = 1'b1; e_npc = pend_addr; e_npc_v = 1'b1;
      if (FetchReady) begin
        e_pcen = 1'b1; e_redir = !pend_flush; e_flush = pend_flush; pend_v = 1'b0;
      end
    end else if (!OperandReady && (waiting || BranchD || JrD)) begin
      e_stall = 1'b1; waiting = 1'b1;
    end else begin
      waiting  = 1'b0;
      dest     = JrD ? JR_addr : JumpD ? J_addr : B_addr;
      is_taken = JrD || JumpD || (BranchD && JudgeRes);
      if (is_taken && FetchReady) begin
        e_npc = dest; e_npc_v = 1'b1; e_pcen = 1'b1; e_redir = 1'b1;
      end else if (is_taken) begin
        e_stall = 1'b1; pend_v = 1'b1; pend_addr = dest; pend_flush = 1'b0;
      end else if (LIKELY_EN && BranchD && LikelyD && FetchReady) begin
        e_flush = 1'b1; e_pcen = 1'b1; e_npc_v = 1'b1;
      end else if (LIKELY_EN && BranchD && LikelyD) begin
        e_stall = 1'b1; pend_v = 1'b1; pend_addr = PC4F; pend_flush = 1'b1;
      end else begin
        e_npc_v = 1'b1; e_pcen = FetchReady; e_stall = !FetchReady;
      end
    end
    if (e_npc_v) chk("m_npc", NPC, e_npc);
    chk("m_pc_en", 32'(PC_En), 32'(e_pcen));
    chk("m_stall", 32'(StallD), 32'(e_stall));
    chk("m_redirect", 32'(Redirect), 32'(e_redir));
    chk("m_flush", 32'(FlushD), 32'(e_flush));
  end

  task automatic idle();
    BranchD = 0; JumpD = 0; JrD = 0; LikelyD = 0; JudgeRes = 0;
    OperandReady = 1; FetchReady = 1;
  endtask

  // Advance to just after the next rising edge; inputs are then changed.
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; idle();
    PC4F = 32'h3004; B_addr = 0; J_addr = 0; JR_addr = 0;
    // Reset pattern for two cycles
    for (int i = 0; i < 2; i++) begin
      #4;
      chk("rst_npc", NPC, 32'h3000);
      chk("rst_pc_en", 32'(PC_En), 0);
      chk("rst_stall", 32'(StallD), 0);
      chk("rst_redirect", 32'(Redirect), 0);
      step();
    end
    reset = 0; #3;
    chk("seq_npc", NPC, 32'h3004);
    chk("seq_pc_en", 32'(PC_En), 1);

    // Taken branch, zero penalty
    step(); BranchD = 1; JudgeRes = 1; B_addr = 32'h3040; #3;
    chk("br_npc", NPC, 32'h3040);
    chk("br_redirect", 32'(Redirect), 1);
    step(); idle(); PC4F = 32'h3044; #3;
    chk("br_redirect_pulse", 32'(Redirect), 0);

    // JR waiting two cycles for forwarded rs
    step(); JrD = 1; JR_addr = 32'h3100; OperandReady = 0; #3;
    chk("jr_stall0", 32'(StallD), 1);
    step(); #3;
    chk("jr_stall1", 32'(StallD), 1);
    step(); OperandReady = 1; #3;
    chk("jr_npc", NPC, 32'h3100);
    chk("jr_redirect", 32'(Redirect), 1);
    chk("jr_stall2", 32'(StallD), 0);

    // Jump parked while Fetch is busy
    step(); idle(); JumpD = 1; J_addr = 32'h0040_0000; FetchReady = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("j_stall", 32'(StallD), 1);
      chk("j_pc_en", 32'(PC_En), 0);
      step(); JumpD = 0;
    end
    FetchReady = 1; #3;
    chk("j_npc", NPC, 32'h0040_0000);
    chk("j_pc_en_exit", 32'(PC_En), 1);
    chk("j_redirect", 32'(Redirect), 1);
    step(); PC4F = 32'h0040_0004; #3;
    chk("j_back_npc", NPC, 32'h0040_0004);
    chk("j_back_redirect", 32'(Redirect), 0);

    // Reset discards a parked target
    step(); JumpD = 1; J_addr = 32'h3200; FetchReady = 0;
    step(); idle(); reset = 1;
    step(); reset = 0; PC4F = 32'h3008; #3;
    chk("rstpend_npc", NPC, 32'h3008);
    chk("rstpend_redirect", 32'(Redirect), 0);

    // Not-taken likely branch
    step(); BranchD = 1; LikelyD = 1; JudgeRes = 0; PC4F = 32'h300c; #3;
    chk("lk_flush", 32'(FlushD), 32'(LIKELY_EN));
    chk("lk_npc", NPC, 32'h300c);
    chk("lk_redirect", 32'(Redirect), 0);

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      step();
      reset        = ($urandom_range(0, 63) == 0);
      BranchD      = ($urandom_range(0, 3) == 0);
      JumpD        = ($urandom_range(0, 5) == 0);
      JrD          = ($urandom_range(0, 5) == 0);
      LikelyD      = $urandom_range(0, 1) == 1;
      JudgeRes     = $urandom_range(0, 1) == 1;
      OperandReady = ($urandom_range(0, 9) < 7);
      FetchReady   = ($urandom_range(0, 9) < 7);
      PC4F = $urandom; B_addr = $urandom; J_addr = $urandom; JR_addr = $urandom;
    end
    step(); reset = 0; idle();
    step(); #6;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
